// File: rtl/mem_access_unit.sv
// Load/store initiator between the MIPS MEM stage and a word-addressed data memory.
// Sub-word stores use read-modify-write. Byte lanes are big-endian.
module mem_access_unit #(
  parameter int unsigned MEM_WORDS = 251,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [31:0]       mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  state_e            r_state, w_state_next;
  logic              r_write, r_signed, r_err;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_word;

  logic              w_accept, w_err, w_idx_oob;
  logic [4:0]        w_shamt;
  logic [31:0]       w_lane, w_load, w_mask, w_merged;

  assign w_accept  = req_valid && (r_state == StIdle);
  assign w_idx_oob = ({2'b00, req_addr[ADDR_W-1:2]} >= ADDR_W'(MEM_WORDS));
  assign w_err     = (req_size == 2'b11) ||
                     ((req_size == SizeHalf) && req_addr[0]) ||
                     ((req_size == SizeWord) && (req_addr[1:0] != 2'b00)) ||
                     w_idx_oob;

  // Right-shift that brings the big-endian lane down to bit 0.
  always_comb begin
    w_shamt = 5'd0;
    if (r_size == SizeByte)      w_shamt = {~r_addr[1:0], 3'b000};
    else if (r_size == SizeHalf) w_shamt = {~r_addr[1], 4'b0000};
  end

  assign w_lane   = r_word >> w_shamt;
  assign w_mask   = ((r_size == SizeByte) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shamt;
  assign w_merged = (r_word & ~w_mask) | ((r_wdata << w_shamt) & w_mask);

  always_comb begin
    w_load = r_word;
    if (r_size == SizeByte)      w_load = {{24{r_signed & w_lane[7]}}, w_lane[7:0]};
    else if (r_size == SizeHalf) w_load = {{16{r_signed & w_lane[15]}}, w_lane[15:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= 2'b00;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_word   <= 32'h0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_write  <= req_write;
        r_signed <= req_signed;
        r_err    <= w_err;
        r_size   <= req_size;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end
      if (r_state == StRd) r_word <= mem_read_data;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_err)                     w_state_next = StDone;
          else if (!req_write)           w_state_next = StRd;
          else if (req_size == SizeWord) w_state_next = StWr;
          else                           w_state_next = StRd;
        end
      end
      StRd:    w_state_next = r_write ? StWr : StDone;
      StWr:    w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    resp_err        = 1'b0;
    resp_rdata      = 32'h0;
    mem_access_addr = '0;
    mem_write_data  = 32'h0;
    mem_write_en    = 1'b0;
    mem_read_en     = 1'b0;
    unique case (r_state)
      StIdle: req_ready = 1'b1;
      StRd: begin
        mem_read_en     = 1'b1;
        mem_access_addr = {2'b00, r_addr[ADDR_W-1:2]};
      end
      StWr: begin
        mem_write_en    = 1'b1;
        mem_access_addr = {2'b00, r_addr[ADDR_W-1:2]};
        mem_write_data  = (r_size == SizeWord) ? r_wdata : w_merged;
      end
      StDone: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        if (!r_err && !r_write) resp_rdata = w_load;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store initiator sitting between the MIPS MEM stage and the word-addressed data memory.
- Accepts byte-addressed load/store requests of byte, halfword or word size.
- Converts each request into word-indexed read/write strobes on the data memory port. Sub-word stores use read-modify-write.
- Returns extracted, extended load data with a one-cycle response pulse, and flags misaligned and out-of-range accesses.

Parameters:
- MEM_WORDS, 251, number of valid word locations (indices 0..MEM_WORDS-1).
- ADDR_W, 32, width of byte address and memory index buses.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; equals (state==IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; sub-word value in low bits.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with resp_valid: misaligned, illegal size or out of range.
- resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors.
- mem_access_addr  out  32  word index = latched req_addr[31:2]; 0 in IDLE/DONE.
- mem_write_data  out  32  write word; 0 unless in WR.
- mem_write_en  out  1  write strobe; memory writes on clk edge.
- mem_read_en  out  1  read strobe.
- mem_read_data  in  32  combinational memory read data.

Behaviour:
- Handshake and latching:
  - Request accepted on a rising edge with req_valid && req_ready.
  - All req_* fields latched on acceptance; later changes are ignored until the next acceptance.
- FSM states: IDLE, RD, WR, DONE.
- Transitions from IDLE on acceptance:
  - Error (size 11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:2]>=MEM_WORDS) -> DONE. No memory strobe is ever asserted.
  - Load -> RD.
  - Word store -> WR.
  - Byte/half store -> RD.
- RD:
  - mem_read_en=1, mem_access_addr=index.
  - At the edge, capture mem_read_data into an internal word register.
  - Load -> DONE; sub-word store -> WR.
- WR:
  - mem_write_en=1.
  - mem_write_data = req_wdata for a word store, else the captured word with the target lane replaced.
  - Next state DONE.
- DONE:
  - resp_valid=1 for exactly this cycle, with resp_err and resp_rdata.
  - Next state IDLE. req_ready=0 during DONE.
- Latency (acceptance edge = cycle 0; resp_valid in cycle N):
  - Error: N=1.
  - Load: N=2.
  - Word store: N=2.
  - Sub-word store: N=3.
- Byte lanes are big-endian.
  - Byte offset 0 = bits 31:24, offset 3 = bits 7:0.
  - Halfword offset 0 = bits 31:16, offset 2 = bits 15:0.
- Load extraction: selected lane right-justified, then sign- or zero-extended to 32 bits. req_signed is ignored for word loads.
- Store merge: only the selected lane is replaced; all other bits equal the captured word.
- mem_read_en and mem_write_en are never high in the same cycle, and neither is high in IDLE or DONE.
- Reset:
  - Synchronous; forces IDLE and clears the captured word and all latched fields.
  - After reset all outputs are 0 except req_ready=1.
  - Reset asserted in RD or WR aborts the access: no strobe in any cycle after the reset edge, and no resp_valid for the aborted request.
- Back-to-back: a new request can be accepted in the cycle after DONE (IDLE). There is no pipelining of requests.

Test Plan:
- Reset, then load word at req_addr=0x10 with mem[4]=0xDEADBEEF:
  - cycle 1: mem_read_en=1, mem_access_addr=4.
  - cycle 2: resp_valid=1, resp_rdata=0xDEADBEEF, resp_err=0.
- Signed byte load, addr=0x11, mem[4]=0x12F45678 -> resp_rdata=0xFFFFFFF4. The same with req_signed=0 -> 0x000000F4.
- Halfword store, addr=0x0A, wdata=0x0000ABCD, mem[2]=0x11223344:
  - cycle 1: read.
  - cycle 2: mem_write_en=1, mem_write_data=0x1122ABCD.
  - cycle 3: resp_valid=1.
  - A subsequent word load of 0x08 returns 0x1122ABCD.
- Misaligned word load addr=0x06, then out-of-range byte load addr=0x3EC (index 251):
  - each: resp_valid=1, resp_err=1, resp_rdata=0 at cycle 1.
  - no read or write strobes at any time.
- Byte store addr=0x20 with rst asserted during the RD cycle:
  - mem_write_en never asserts and resp_valid never asserts.
  - mem[8] is unchanged.
  - req_ready=1 the cycle after reset.
- Back-to-back word store 0x55AA55AA to 0x04, then word load 0x04:
  - the second request is accepted the cycle after DONE.
  - load returns 0x55AA55AA.
  - req_ready is low during every cycle of RD, WR and DONE.
